// File: rtl/prog_loader_ctrl.sv
// -----------------------------------------------------------------------------
// prog_loader_ctrl
//   Loads a program image from a UART byte stream into a 32-bit program ROM.
//   Image framing: SYNC_BYTE, count lo, count hi, N x 4 data bytes (LE), chk.
//   The checksum is the XOR of every byte after SYNC_BYTE (count + data bytes).
//
// Ports
//   Upg_clk_i   in   single rising-edge clock
//   Upg_rst_i   in   synchronous active-high reset
//   Rx_vld_i    in   one-cycle byte strobe from UART receiver
//   Rx_dat_i    in   received byte (valid with Rx_vld_i)
//   Upg_wen_o   out  ROM write enable, one-cycle pulse per word
//   Upg_adr_o   out  ROM word address (held between pulses)
//   Upg_dat_o   out  ROM write data (held between pulses)
//   Upg_done_o  out  image loaded and checksum verified
//   Busy_o      out  load in progress
//   Err_o       out  last load failed (bad count, checksum or timeout)
// -----------------------------------------------------------------------------
module prog_loader_ctrl #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [23:0] TIMEOUT   = 24'd1_000_000
) (
  input  logic              Upg_clk_i,
  input  logic              Upg_rst_i,
  input  logic              Rx_vld_i,
  input  logic [7:0]        Rx_dat_i,
  output logic              Upg_wen_o,
  output logic [ADDR_W-1:0] Upg_adr_o,
  output logic [31:0]       Upg_dat_o,
  output logic              Upg_done_o,
  output logic              Busy_o,
  output logic              Err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Largest legal word count is the full ROM depth.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q,   cnt_d;    // word count N
  logic [ADDR_W-1:0]   widx_q,  widx_d;   // index of word being assembled
  logic [1:0]          bcnt_q,  bcnt_d;   // byte position inside the word
  logic [31:0]         asm_q,   asm_d;    // bytes 0..2 of the current word
  logic [7:0]          csum_q,  csum_d;
  logic [23:0]         gap_q,   gap_d;
  logic                fin_q,   fin_d;    // last word received, pulse in flight
  logic                wen_q,   wen_d;
  logic [ADDR_W-1:0]   adr_q,   adr_d;
  logic [31:0]         dat_q,   dat_d;

  logic                busy;
  logic                tmo;
  logic                last_word;
  logic [15:0]         n_new;

  assign busy = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                (state_q == S_DATA)   || (state_q == S_CHK);

  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo = busy && !Rx_vld_i &&
               (({1'b0, gap_q} + 25'd1) >= {1'b0, TIMEOUT});

  assign last_word = (({{(32-ADDR_W){1'b0}}, widx_q} + 32'd1) == {16'd0, cnt_q});
  assign n_new     = {Rx_dat_i, cnt_q[7:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    fin_d   = fin_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;

    // Gap counter runs only while a load is in progress.
    if (!busy || Rx_vld_i) gap_d = 24'd0;
    else                   gap_d = gap_q + 24'd1;

    case (state_q)
      S_IDLE: begin
        if (Rx_vld_i && (Rx_dat_i == SYNC_BYTE)) begin
          state_d = S_CNT_LO;
          csum_d  = 8'd0;
        end
      end

      S_CNT_LO: begin
        if (Rx_vld_i) begin
          cnt_d[7:0] = Rx_dat_i;
          csum_d     = csum_q ^ Rx_dat_i;
          state_d    = S_CNT_HI;
        end
      end

      S_CNT_HI: begin
        if (Rx_vld_i) begin
          cnt_d  = n_new;
          csum_d = csum_q ^ Rx_dat_i;
          widx_d = '0;
          bcnt_d = 2'd0;
          fin_d  = 1'b0;
          if (n_new == 16'd0)                  state_d = S_CHK;
          else if ({17'd0, n_new} > MAX_WORDS) state_d = S_ERR;
          else                                 state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (fin_q) begin
          // Final word's write pulse is on the bus this cycle; we only move
          // to CHK afterwards so wen never overlaps CHK. A checksum byte
          // arriving right now is judged here instead of being lost.
          fin_d = 1'b0;
          if (Rx_vld_i) state_d = (Rx_dat_i == csum_q) ? S_DONE : S_ERR;
          else          state_d = S_CHK;
        end else if (Rx_vld_i) begin
          csum_d = csum_q ^ Rx_dat_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wen_d  = 1'b1;
            adr_d  = widx_q;
            dat_d  = {Rx_dat_i, asm_q[23:0]};
            widx_d = widx_q + ADDR_W'(1);
            if (last_word) fin_d = 1'b1;
          end else begin
            asm_d[{bcnt_q, 3'b000} +: 8] = Rx_dat_i;
          end
        end
      end

      S_CHK: begin
        if (Rx_vld_i) state_d = (Rx_dat_i == csum_q) ? S_DONE : S_ERR;
      end

      S_DONE: begin
        // Sticky until reset; the CPU owns the ROM now.
      end

      S_ERR: begin
        if (Rx_vld_i && (Rx_dat_i == SYNC_BYTE)) begin
          state_d = S_CNT_LO;
          csum_d  = 8'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (tmo) begin
      state_d = S_ERR;
      fin_d   = 1'b0;
    end
  end

  always_ff @(posedge Upg_clk_i) begin
    if (Upg_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      widx_q  <= '0;
      bcnt_q  <= 2'd0;
      asm_q   <= 32'd0;
      csum_q  <= 8'd0;
      gap_q   <= 24'd0;
      fin_q   <= 1'b0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      gap_q   <= gap_d;
      fin_q   <= fin_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign Upg_wen_o  = wen_q;
  assign Upg_adr_o  = adr_q;
  assign Upg_dat_o  = dat_q;
  assign Upg_done_o = (state_q == S_DONE);
  assign Err_o      = (state_q == S_ERR);
  assign Busy_o     = busy;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
module tb_prog_loader_ctrl;

  localparam int AW = 14;

  typedef logic [31:0] wq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_vld = 1'b0;
  logic [7:0]    rx_dat = 8'd0;
  logic          wen;
  logic [AW-1:0] adr;
  logic [31:0]   dat;
  logic          done, busy, err;

  prog_loader_ctrl #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT(24'd100)) dut (
    .Upg_clk_i (clk),
    .Upg_rst_i (rst),
    .Rx_vld_i  (rx_vld),
    .Rx_dat_i  (rx_dat),
    .Upg_wen_o (wen),
    .Upg_adr_o (adr),
    .Upg_dat_o (dat),
    .Upg_done_o(done),
    .Busy_o    (busy),
    .Err_o     (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_cyc;
  int dbl   = 0;
  logic prev_wen = 1'b0;

  // Observed writes
  logic [AW-1:0] oa[$];
  logic [31:0]   od[$];
  int            oc[$];
  // Expected writes from the reference model
  logic [AW-1:0] ea[$];
  logic [31:0]   ed[$];
  int            ec[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wen) begin
      oa.push_back(adr);
      od.push_back(dat);
      oc.push_back(cyc);
      if (prev_wen) dbl++;
    end
    prev_wen = wen;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    rx_vld   = 1'b1;
    rx_dat   = b;
    last_cyc = cyc;
    @(negedge clk);
    rx_vld   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    oa.delete(); od.delete(); oc.delete();
    ea.delete(); ed.delete(); ec.delete();
    dbl = 0;
  endtask

  // Reference model: word i lands at address i, one cycle after its 4th
  // byte; checksum is XOR of every byte sent after the sync byte.
  task automatic send_image(input wq_t words, input logic [15:0] n,
                            input bit bad_chk, input int maxgap);
    logic [7:0] cs;
    logic [31:0] w;
    cs = 8'd0;
    send(8'hA5, maxgap);
    send(n[7:0], maxgap);  cs ^= n[7:0];
    send(n[15:8], maxgap); cs ^= n[15:8];
    for (int i = 0; i < int'(n); i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        send(w[8*b +: 8], maxgap);
        cs ^= w[8*b +: 8];
      end
      ea.push_back(AW'(i));
      ed.push_back(w);
      ec.push_back(last_cyc + 1);
    end
    send(bad_chk ? ~cs : cs, maxgap);
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_nwr"}, 64'(oa.size()), 64'(ea.size()));
    n = (oa.size() < ea.size()) ? oa.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_adr%0d", tag, i), 64'(oa[i]), 64'(ea[i]));
      chk($sformatf("%s_dat%0d", tag, i), 64'(od[i]), 64'(ed[i]));
      chk($sformatf("%s_cyc%0d", tag, i), 64'(oc[i]), 64'(ec[i]));
    end
    chk({tag, "_wen_1cyc"}, 64'(dbl), 64'd0);
    oa.delete(); od.delete(); oc.delete();
    ea.delete(); ed.delete(); ec.delete();
    dbl = 0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic b);
    chk({tag, "_done"}, 64'(done), 64'(d));
    chk({tag, "_err"},  64'(err),  64'(e));
    chk({tag, "_busy"}, 64'(busy), 64'(b));
  endtask

  initial begin
    wq_t ws;
    logic [15:0] n;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_adr", 64'(adr), 64'd0);
    chk("rst_dat", 64'(dat), 64'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // ---- fixed two-word image, first byte right after reset release
    ws = '{32'h44332211, 32'h88776655};
    send_image(ws, 16'd2, 1'b0, 0);
    repeat (2) @(negedge clk);
    check_writes("img2");
    check_status("img2", 1'b1, 1'b0, 1'b0);
    chk("img2_adr_hold", 64'(adr), 64'd1);
    chk("img2_dat_hold", 64'(dat), 64'h88776655);
    // DONE ignores everything, including a new sync byte
    send(8'hA5, 1); send(8'h01, 1); send(8'h00, 1);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1);
    repeat (2) @(negedge clk);
    check_writes("done_ign");
    check_status("done_ign", 1'b1, 1'b0, 1'b0);

    // ---- zero-length image, with junk bytes ignored in IDLE
    do_reset();
    send(8'h5A, 1); send(8'h00, 1); send(8'hFF, 1);
    check_status("idle_junk", 1'b0, 1'b0, 1'b0);
    ws = {};
    send_image(ws, 16'd0, 1'b0, 1);
    repeat (2) @(negedge clk);
    check_writes("img0");
    check_status("img0", 1'b1, 1'b0, 1'b0);

    // ---- bad checksum, then recovery with a fresh image
    do_reset();
    ws = {};
    n = 16'($urandom_range(6, 1));
    for (int i = 0; i < int'(n); i++) ws.push_back($urandom);
    send_image(ws, n, 1'b1, 2);
    repeat (2) @(negedge clk);
    check_writes("badchk");
    check_status("badchk", 1'b0, 1'b1, 1'b0);
    send(8'h5A, 0);
    check_status("err_junk", 1'b0, 1'b1, 1'b0);
    ws = {};
    n = 16'($urandom_range(6, 1));
    for (int i = 0; i < int'(n); i++) ws.push_back($urandom);
    send_image(ws, n, 1'b0, 2);
    repeat (2) @(negedge clk);
    check_writes("resend");
    check_status("resend", 1'b1, 1'b0, 1'b0);

    // ---- inter-byte timeout after 2 data bytes (TIMEOUT = 100)
    do_reset();
    send(8'hA5, 0); send(8'h03, 0); send(8'h00, 0);
    send(8'h11, 0); send(8'h22, 0);
    repeat (90) @(negedge clk);
    check_status("tmo_early", 1'b0, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    check_status("tmo", 1'b0, 1'b1, 1'b0);
    check_writes("tmo");

    // ---- oversize count 0x4001 with a 14-bit ROM
    do_reset();
    send(8'hA5, 0); send(8'h01, 0); send(8'h40, 0);
    check_status("ovf", 1'b0, 1'b1, 1'b0);
    send(8'h00, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    repeat (2) @(negedge clk);
    check_writes("ovf");
    check_status("ovf_hold", 1'b0, 1'b1, 1'b0);

    // ---- reset mid-DATA after word 0, then a fresh load from address 0
    do_reset();
    send(8'hA5, 0); send(8'h03, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    ea.push_back('0); ed.push_back(32'hDEADBEEF); ec.push_back(last_cyc + 1);
    send(8'h01, 0); send(8'h02, 0);
    check_status("mid", 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_wen", 64'(wen), 64'd0);
    chk("midrst_adr", 64'(adr), 64'd0);
    chk("midrst_dat", 64'(dat), 64'd0);
    check_status("midrst", 1'b0, 1'b0, 1'b0);
    check_writes("midrst");
    ws = {};
    n = 16'($urandom_range(5, 2));
    for (int i = 0; i < int'(n); i++) ws.push_back($urandom);
    send_image(ws, n, 1'b0, 1);
    repeat (2) @(negedge clk);
    check_writes("fresh");
    check_status("fresh", 1'b1, 1'b0, 1'b0);

    // ---- randomized images, alternating back-to-back and gappy streams
    for (int t = 0; t < 4; t++) begin
      do_reset();
      ws = {};
      n = 16'($urandom_range(8, 1));
      for (int i = 0; i < int'(n); i++) ws.push_back($urandom);
      send_image(ws, n, 1'b0, (t % 2 == 0) ? 0 : 3);
      repeat (2) @(negedge clk);
      check_writes($sformatf("rnd%0d", t));
      check_status($sformatf("rnd%0d", t), 1'b1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
